mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch requester (FETCH state) and the load/store requester (MEM_READ/MEM_WRITE states) of the multicycle core.
- Runs a fixed-latency single-outstanding transaction sequencer with round-robin tie-breaking and a per-requester req/ack handshake.
- Sits between the control/datapath and the memory model.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port arbiter for fetch and load/store requesters
// Single-outstanding, fixed-latency sequencer: IDLE -> WAIT (MEM_LAT edges) -> RESP.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              if_ack,
  output logic              ls_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_ls_q, last_ls_d;
  logic                win_ls_q, win_ls_d;
  logic                if_ack_q, if_ack_d;
  logic                ls_ack_q, ls_ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                grant_ls;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_ls_d   = last_ls_q;
    win_ls_d    = win_ls_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_ls    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          // On contention the requester that did not win last time goes first.
          grant_ls  = ls_req && (!if_req || !last_ls_q);
          win_ls_d  = grant_ls;
          last_ls_d = grant_ls;
          mem_en_d  = 1'b1;
          cnt_d     = LAT;
          state_d   = WAIT;
          if (grant_ls) begin
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d  = mem_rdata;
          if_ack_d = !win_ls_q;
          ls_ack_d = win_ls_q;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_ls_q   <= 1'b1;
      win_ls_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_ls_q   <= last_ls_d;
      win_ls_q    <= win_ls_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven bench for mem_port_arbiter (MEM_LAT 2, plus 1 and 15 builds)
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic        if_ack, ls_ack, busy, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .if_ack(if_ack), .ls_ack(ls_ack), .rdata(rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  logic        req1, ia1, la1, busy1, en1, we1;
  logic [31:0] rd1, ma1, mwd1;
  logic [31:0] mrd1 = 32'hC0FF_EE01;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .if_req(req1), .if_addr(32'h4), .ls_req(1'b0), .ls_we(1'b0),
    .ls_addr(32'h0), .ls_wdata(32'h0), .if_ack(ia1), .ls_ack(la1), .rdata(rd1),
    .busy(busy1), .mem_en(en1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(mwd1),
    .mem_rdata(mrd1));

  logic        req15, ia15, la15, busy15, en15, we15;
  logic [31:0] rd15, ma15, mwd15;
  logic [31:0] mrd15 = 32'hC0FF_EE0F;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_lat15 (
    .clk(clk), .rst(rst), .if_req(1'b0), .if_addr(32'h0), .ls_req(req15), .ls_we(1'b0),
    .ls_addr(32'h8), .ls_wdata(32'h0), .if_ack(ia15), .ls_ack(la15), .rdata(rd15),
    .busy(busy15), .mem_en(en15), .mem_we(we15), .mem_addr(ma15), .mem_wdata(mwd15),
    .mem_rdata(mrd15));

  // Expected field packs as {if_ack, ls_ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}.
  typedef struct {
    logic        ireq, lreq, we;
    logic [31:0] iaddr, laddr, wdata, mrd;
    logic [100:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic ireq, lreq, we, input logic [31:0] iaddr, laddr, wdata, mrd,
                     input logic ia, la, input logic [31:0] rd, input logic bz, en, mwe,
                     input logic [31:0] maddr, mwd);
    vec_t v;
    v.ireq = ireq; v.lreq = lreq; v.we = we;
    v.iaddr = iaddr; v.laddr = laddr; v.wdata = wdata; v.mrd = mrd;
    v.exp = {ia, la, rd, bz, en, mwe, maddr, mwd};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [100:0] act, input logic [100:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [100:0] outs();
    return {if_ack, ls_ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  initial begin
    int n;
    int acks;
    rst = 1'b1; if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; req1 = 0; req15 = 0;

    // IF load of 0x10
    add(1,0,0, 32'h10,32'h0,32'h0,32'hDEADBEEF, 0,0,32'h0,1,1,0,32'h10,32'h0);
    add(1,0,0, 32'h10,32'h0,32'h0,32'hDEADBEEF, 0,0,32'h0,1,0,0,32'h10,32'h0);
    add(1,0,0, 32'h10,32'h0,32'h0,32'hDEADBEEF, 1,0,32'hDEADBEEF,1,0,0,32'h10,32'h0);
    add(0,0,0, 32'h10,32'h0,32'h0,32'hDEADBEEF, 0,0,32'hDEADBEEF,0,0,0,32'h10,32'h0);
    // LS store to 0x100
    add(0,1,1, 32'h10,32'h100,32'h12345678,32'hA5A5A5A5, 0,0,32'hDEADBEEF,1,1,1,32'h100,32'h12345678);
    add(0,1,1, 32'h10,32'h100,32'h12345678,32'hA5A5A5A5, 0,0,32'hDEADBEEF,1,0,1,32'h100,32'h12345678);
    add(0,1,1, 32'h10,32'h100,32'h12345678,32'hA5A5A5A5, 0,1,32'hA5A5A5A5,1,0,1,32'h100,32'h12345678);
    add(0,0,1, 32'h10,32'h100,32'h12345678,32'hA5A5A5A5, 0,0,32'hA5A5A5A5,0,0,1,32'h100,32'h12345678);
    // both held: IF, LS, IF, LS
    add(1,1,0, 32'h20,32'h200,32'h55,32'h1, 0,0,32'hA5A5A5A5,1,1,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h1, 0,0,32'hA5A5A5A5,1,0,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h1, 1,0,32'h1,1,0,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h1, 0,0,32'h1,0,0,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h2, 0,0,32'h1,1,1,0,32'h200,32'h55);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h2, 0,0,32'h1,1,0,0,32'h200,32'h55);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h2, 0,1,32'h2,1,0,0,32'h200,32'h55);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h2, 0,0,32'h2,0,0,0,32'h200,32'h55);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h3, 0,0,32'h2,1,1,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h3, 0,0,32'h2,1,0,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h3, 1,0,32'h3,1,0,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h3, 0,0,32'h3,0,0,0,32'h20,32'h0);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h4, 0,0,32'h3,1,1,0,32'h200,32'h55);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h4, 0,0,32'h3,1,0,0,32'h200,32'h55);
    add(1,1,0, 32'h20,32'h200,32'h55,32'h4, 0,1,32'h4,1,0,0,32'h200,32'h55);
    add(0,0,0, 32'h20,32'h200,32'h55,32'h4, 0,0,32'h4,0,0,0,32'h200,32'h55);
    // ls_req rises during IF WAIT; if_addr change after grant ignored
    add(1,0,0, 32'h30,32'h200,32'h55,32'h7, 0,0,32'h4,1,1,0,32'h30,32'h0);
    add(1,1,1, 32'h44,32'h300,32'h99,32'h7, 0,0,32'h4,1,0,0,32'h30,32'h0);
    add(1,1,1, 32'h44,32'h300,32'h99,32'h7, 1,0,32'h7,1,0,0,32'h30,32'h0);
    add(0,1,1, 32'h44,32'h300,32'h99,32'h7, 0,0,32'h7,0,0,0,32'h30,32'h0);
    add(0,1,1, 32'h44,32'h300,32'h99,32'h8, 0,0,32'h7,1,1,1,32'h300,32'h99);
    add(0,1,1, 32'h44,32'h300,32'h99,32'h8, 0,0,32'h7,1,0,1,32'h300,32'h99);
    add(0,1,1, 32'h44,32'h300,32'h99,32'h8, 0,1,32'h8,1,0,1,32'h300,32'h99);
    add(0,0,1, 32'h44,32'h300,32'h99,32'h8, 0,0,32'h8,0,0,1,32'h300,32'h99);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), '0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if_req = vecs[i].ireq; ls_req = vecs[i].lreq; ls_we = vecs[i].we;
      if_addr = vecs[i].iaddr; ls_addr = vecs[i].laddr; ls_wdata = vecs[i].wdata;
      mem_rdata = vecs[i].mrd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // reset in the WAIT cycle after mem_en abandons the transaction
    if_req = 1; ls_req = 0; ls_we = 0; if_addr = 32'h40; mem_rdata = 32'h1111;
    @(posedge clk); #1;
    chk("rst_seq_mem_en", {100'h0, mem_en}, {100'h0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1; if_req = 0;
    @(posedge clk); #1;
    chk("rst_seq_outputs_zero", outs(), '0);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (if_ack || ls_ack || busy) acks++;
    end
    chk("rst_seq_no_ack", 101'(acks), 101'(0));
    // after reset, contention goes to IF first
    if_req = 1; ls_req = 1; if_addr = 32'h50; ls_addr = 32'h500; mem_rdata = 32'h2222;
    @(posedge clk); #1;
    chk("post_rst_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h50});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_ack", {if_ack, ls_ack, rdata}, {1'b1, 1'b0, 32'h2222});
    if_req = 0; ls_req = 0;
    @(posedge clk); #1;

    // MEM_LAT=1: ack in cycle 2
    req1 = 1; n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ia1) begin n = k; break; end
    end
    req1 = 0;
    chk("lat1_ack_cycle", 101'(n), 101'(2));
    chk("lat1_rdata", 101'(rd1), 101'(32'hC0FF_EE01));
    @(posedge clk); #1;
    chk("lat1_ack_one_cycle", {100'h0, ia1}, '0);

    // MEM_LAT=15: ack in cycle 16
    req15 = 1; n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (la15) begin n = k; break; end
    end
    req15 = 0;
    chk("lat15_ack_cycle", 101'(n), 101'(16));
    chk("lat15_rdata", 101'(rd15), 101'(32'hC0FF_EE0F));
    @(posedge clk); #1;
    chk("lat15_ack_one_cycle", {100'h0, la15}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
